// File: rtl/serdes_pkg.sv
// Shared definitions for the SERDES serializer/deserializer datapath.
//   ser_state_t : serializer FSM states (IDLE, SEND)
//   cnt_w()     : width of the word counter for a given words-per-message
package serdes_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Counter width for n words; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parallel_serializer_if.sv
// Valid/ready stream of W-bit messages.
//   val : producer has a message
//   rdy : consumer can take it (transfer when val & rdy at posedge clk)
//   msg : message payload
// Modports: master = producer side, slave = consumer side.
interface parallel_serializer_if #(
    parameter int W = 32
) ();
    logic         val;
    logic         rdy;
    logic [W-1:0] msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/serializer_word_mux.sv
// Combinational N_SAMPLES:1 selector of BIT_WIDTH-bit words out of a packed
// message (word i at words[i*BIT_WIDTH +: BIT_WIDTH]).
//   words : packed parallel message
//   sel   : index of the word to present
//   word  : selected word (zero for an out-of-range index)
module serializer_word_mux
    import serdes_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = cnt_w(N_SAMPLES)
) (
    input  logic [BIT_WIDTH*N_SAMPLES-1:0] words,
    input  logic [CNT_W-1:0]               sel,
    output logic [BIT_WIDTH-1:0]           word
);

    always_comb begin
        // NOTE: assign a default before the loop so every path drives word; no latch.
        word = '0;
        for (int i = 0; i < N_SAMPLES; i++) begin
            if (sel == CNT_W'(i)) word = words[i*BIT_WIDTH +: BIT_WIDTH];
        end
    end

endmodule

// File: rtl/parallel_serializer.sv
// Parallel-to-serial stage: takes one N_SAMPLES-word message on recv and
// emits its words on send, word 0 first.
//   clk   : clock, all state on posedge
//   reset : synchronous, active-low
//   recv  : slave stream, BIT_WIDTH*N_SAMPLES-bit parallel messages
//   send  : master stream, BIT_WIDTH-bit serial words
// Build option: define SERIALIZER_OVERLAP_EN to accept the next message in
// the same cycle as the last word leaves (no IDLE bubble between messages).
module parallel_serializer
    import serdes_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    parallel_serializer_if.slave   recv,
    parallel_serializer_if.master  send
);

    localparam int CNT_W = cnt_w(N_SAMPLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

    ser_state_t                     state;
    logic [CNT_W-1:0]               count;
    logic [BIT_WIDTH*N_SAMPLES-1:0] buffer;
    logic [BIT_WIDTH-1:0]           cur_word;
    logic                           last_word;
    logic                           recv_fire;
    logic                           send_fire;

    assign last_word = (count == LAST);

    // Outputs decode the registered state; reset forces them low at once.
`ifdef SERIALIZER_OVERLAP_EN
    assign recv.rdy = reset && ((state == IDLE) ||
                                (state == SEND && last_word && send.rdy));
`else
    assign recv.rdy = reset && (state == IDLE);
`endif
    assign send.val = reset && (state == SEND);
    assign send.msg = reset ? cur_word : '0;

    assign recv_fire = recv.val && recv.rdy;
    assign send_fire = send.val && send.rdy;

    serializer_word_mux #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_SAMPLES (N_SAMPLES),
        .CNT_W     (CNT_W)
    ) u_word_mux (
        .words (buffer),
        .sel   (count),
        .word  (cur_word)
    );

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values; the buffer is reset because it drives send_msg.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            buffer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (recv_fire) begin
                        buffer <= recv.msg;
                        count  <= '0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (send_fire) begin
                        if (!last_word) begin
                            count <= count + CNT_W'(1);
                        end else if (recv_fire) begin
                            // Only reachable with overlap: chain straight into
                            // the next message without an IDLE cycle.
                            buffer <= recv.msg;
                            count  <= '0;
                        end else begin
                            count <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parallel_serializer.sv
// Self-checking bench for parallel_serializer (BIT_WIDTH=8, N_SAMPLES=4).
// The reference model is a queue of words still owed downstream: an accepted
// message appends its four words, a downstream handshake removes the front.
module tb_parallel_serializer;

    localparam int BW = 8;
    localparam int NS = 4;
`ifdef SERIALIZER_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parallel_serializer_if #(.W(BW*NS)) recv_if ();
    parallel_serializer_if #(.W(BW))    send_if ();

    parallel_serializer #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
        .clk   (clk),
        .reset (reset),
        .recv  (recv_if),
        .send  (send_if)
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int t04    = -1;
    int t05    = -1;
    logic [BW-1:0] q[$];
    logic [BW-1:0] sent[$];
    logic [BW*NS-1:0] held_msg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance.
    task automatic step();
        logic exp_rdy, exp_val, s_fire, r_fire;
        #1;
        if (!reset) begin
            exp_rdy = 1'b0;
            exp_val = 1'b0;
        end else begin
            exp_val = (q.size() != 0);
            exp_rdy = (q.size() == 0) || (OVERLAP && q.size() == 1 && send_if.rdy);
        end
        check("recv_rdy", recv_if.rdy, exp_rdy);
        check("send_val", send_if.val, exp_val);
        if (!reset)       check("send_msg_rst", send_if.msg, 0);
        else if (exp_val) check("send_msg", send_if.msg, q[0]);
        s_fire = exp_val && send_if.rdy;
        r_fire = exp_rdy && recv_if.val;
        if (s_fire) begin
            sent.push_back(q[0]);
            if (q[0] == 8'h04) t04 = cyc;
            if (q[0] == 8'h05) t05 = cyc;
            void'(q.pop_front());
        end
        if (r_fire) begin
            n_acc++;
            for (int i = 0; i < NS; i++) q.push_back(recv_if.msg[i*BW +: BW]);
        end
        if (!reset) q.delete();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        reset       = 1'b0;
        recv_if.val = 1'b0;
        recv_if.msg = '0;
        send_if.rdy = 1'b0;

        // 1. reset for two cycles, then ready in the first cycle after
        step();
        step();
        reset = 1'b1;
        step();

        // 2. one message, downstream always ready
        sent.delete();
        recv_if.msg = 32'hDDCCBBAA;
        recv_if.val = 1'b1;
        send_if.rdy = 1'b1;
        step();
        recv_if.val = 1'b0;
        repeat (5) step();
        check("t2_count", sent.size(), 4);
        check("t2_order", {sent[0], sent[1], sent[2], sent[3]}, 32'hAABBCCDD);

        // 3. stall for three cycles while BB is shown
        sent.delete();
        recv_if.val = 1'b1;
        step();
        recv_if.val = 1'b0;
        step();
        send_if.rdy = 1'b0;
        repeat (3) step();
        check("t3_bb_held", send_if.msg, 8'hBB);
        send_if.rdy = 1'b1;
        repeat (4) step();
        check("t3_order", {sent[0], sent[1], sent[2], sent[3]}, 32'hAABBCCDD);

        // 4. back-to-back messages with recv_val held high
        n_acc = 0;
        recv_if.msg = 32'h04030201;
        recv_if.val = 1'b1;
        step();
        recv_if.msg = 32'h08070605;
        for (int i = 0; i < 10 && n_acc < 2; i++) step();
        check("t4_accepts", n_acc, 2);
        recv_if.val = 1'b0;
        repeat (8) step();
        check("t4_gap", t05 - t04, OVERLAP ? 1 : 2);

        // 5. reset while CC is shown drops the rest of the message
        recv_if.msg = 32'hDDCCBBAA;
        recv_if.val = 1'b1;
        step();
        recv_if.val = 1'b0;
        step();
        step();
        check("t5_cc_shown", send_if.msg, 8'hCC);
        reset = 1'b0;
        step();
        reset = 1'b1;
        sent.delete();
        recv_if.msg = 32'h87654321;
        recv_if.val = 1'b1;
        step();
        recv_if.val = 1'b0;
        repeat (5) step();
        check("t5_restart", {sent[0], sent[1], sent[2], sent[3]}, 32'h21436587);
        check("t5_no_dd", sent.size(), 4);

        // 6. recv_msg churns while sending; emitted words are unaffected
        sent.delete();
        held_msg    = 32'h5A3C1E0F;
        recv_if.msg = held_msg;
        recv_if.val = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            recv_if.msg = $urandom;
            step();
        end
        recv_if.msg = $urandom;
        step();
        recv_if.val = 1'b0;
        repeat (6) step();
        check("t6_order", {sent[3], sent[2], sent[1], sent[0]}, held_msg);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            recv_if.val = ($urandom_range(1, 0) == 1);
            recv_if.msg = $urandom;
            send_if.rdy = ($urandom_range(9, 0) < 7);
            step();
        end
        recv_if.val = 1'b0;
        send_if.rdy = 1'b1;
        for (int i = 0; i < 12 && q.size() != 0; i++) step();
        check("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
